// File: rtl/dmem_responder_if.sv
// LSU <-> data-memory request/response bundle.
// Latency: none; a set of wires.
// Backpressure: none; the LSU keeps at most one request outstanding.
//
// Signals:
//   mem_req    LSU -> mem : one-cycle request pulse
//   mem_wen    LSU -> mem : 1 = store, 0 = load
//   mem_addr   LSU -> mem : byte address
//   mem_wdata  LSU -> mem : store data, already lane-shifted
//   mem_wmask  LSU -> mem : byte-lane write enables
//   mem_rvalid mem -> LSU : one-cycle response pulse
//   mem_rdata  mem -> LSU : response data, valid with mem_rvalid
interface dmem_responder_if;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data-memory responder standing in for data SRAM behind the LSU.
// Latency: mem_rvalid pulses exactly LATENCY cycles after the mem_req pulse.
// Backpressure: none; requests arriving while a request is pending are dropped.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   mem         dmem_responder_if.slave (request in, response out)
//   busy        a request has been accepted and not yet answered
//   err         sticky out-of-range flag (only with DMEM_RANGE_CHECK_EN)
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag and suppress accesses
// outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS). Without it addresses wrap
// modulo the array size and err is tied low.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  mem,
    output logic             busy,
    output logic             err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam bit          LAT_ONE  = (LATENCY == 1);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        respond;

    // Request captured at accept time.
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wmask;

    // Request as seen at the response edge. With LATENCY = 1 the response
    // edge is the accept edge, so the live inputs are used directly.
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    logic [31:0] off;
    logic [AW-1:0] idx;
    logic [1:0]  sh;
    logic [31:0] old_word;
    logic [31:0] rsp_data;
    logic        in_range;
    logic        wr_en;

    logic [31:0] ram [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        respond   = 1'b0;
        case (state)
            IDLE: begin
                if (mem.mem_req) begin
                    accept = 1'b1;
                    if (LAT_ONE) begin
                        respond = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // mem_req is ignored here; the LSU never overlaps requests.
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    respond   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign busy = (state == WAIT);

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_wen   <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_wmask <= 4'd0;
        end else if (accept) begin
            lat_wen   <= mem.mem_wen;
            lat_addr  <= mem.mem_addr;
            lat_wdata <= mem.mem_wdata;
            lat_wmask <= mem.mem_wmask;
        end
    end

    assign r_wen   = LAT_ONE ? mem.mem_wen   : lat_wen;
    assign r_addr  = LAT_ONE ? mem.mem_addr  : lat_addr;
    assign r_wdata = LAT_ONE ? mem.mem_wdata : lat_wdata;
    assign r_wmask = LAT_ONE ? mem.mem_wmask : lat_wmask;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign off = r_addr - ADDR_BASE;
    assign idx = off[AW+1:2];
    assign sh  = r_addr[1:0];

`ifdef DMEM_RANGE_CHECK_EN
    // 33-bit compare so a window ending at 4 GiB does not overflow.
    assign in_range = ({1'b0, r_addr} >= {1'b0, ADDR_BASE}) &&
                      ({1'b0, r_addr} <  ({1'b0, ADDR_BASE} + SPAN));
`else
    assign in_range = 1'b1;
`endif

    // Bits of the offset above the array and below the word are not part of
    // the index in the wrapping build.
    logic unused_off;
    assign unused_off = ^{off[31:AW+2], off[1:0], SPAN};

    // ------------------------------------------------------------------
    // Array: read old word, then byte-masked write at the response edge
    // ------------------------------------------------------------------
    assign old_word = ram[idx];

    // Loads are right-aligned so the LSU only has to extend; stores return
    // the pre-write word untouched.
    always_comb begin
        rsp_data = 32'd0;
        if (in_range) begin
            if (r_wen) rsp_data = old_word;
            else       rsp_data = old_word >> {sh, 3'b000};
        end
    end

    // rst_n gate keeps a LATENCY = 1 request presented during reset from
    // committing; for longer latencies the FSM is already held in IDLE.
    assign wr_en = respond && r_wen && in_range && rst_n;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) ram[idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_rvalid <= 1'b0;
            mem.mem_rdata  <= 32'd0;
        end else begin
            mem.mem_rvalid <= respond;
            // rdata holds between pulses.
            if (respond) mem.mem_rdata <= rsp_data;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err_q <= 1'b0;
        else if (respond && !in_range) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY = 2.
// Latency: checks that every response lands exactly LATENCY cycles after the request.
// Backpressure: checks that requests issued while busy are dropped.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_BASE   (32'h8000_0000),
        .DEPTH_WORDS (4096),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus),
        .busy  (busy),
        .err   (err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one request, then wait (bounded) for the response. Returns in
    // the cycle where mem_rvalid is high; lat = 0 means no response seen.
    task automatic xfer(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        output logic [31:0] data, output int lat);
        bus.mem_req   = 1'b1;
        bus.mem_wen   = wen;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wmask = wmask;
        tick();
        bus.mem_req   = 1'b0;
        lat  = 0;
        data = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_rvalid) begin
                lat  = k;
                data = bus.mem_rdata;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          pulses;

        bus.mem_req   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wmask = 4'd0;

        // Reset state
        tick();
        tick();
        check("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
        check("rst_rdata",  bus.mem_rdata,       32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_err",    32'(err),            32'd0);
        rst_n = 1'b1;
        tick();

        // SW then LW
        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, d, lat);
        check("sw_latency", 32'(lat), 32'(LAT));
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'b0000, d, lat);
        check("lw_latency", 32'(lat), 32'(LAT));
        check("lw_data", d, 32'hDEAD_BEEF);

        // SB over an existing word
        xfer(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b1111, d, lat);
        check("sw2_old", d, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h8000_0013, 32'h5A00_0000, 4'b1000, d, lat);
        check("sb_old", d, 32'h1122_3344);
        xfer(1'b0, 32'h8000_0013, 32'h0, 4'b0000, d, lat);
        check("lb_13", d, 32'h0000_005A);
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'b0000, d, lat);
        check("lw_10_merged", d, 32'h5A22_3344);

        // LH from upper half
        xfer(1'b1, 32'h8000_0010, 32'hABCD_1234, 4'b1111, d, lat);
        xfer(1'b0, 32'h8000_0012, 32'h0, 4'b0000, d, lat);
        check("lh_12", d, 32'h0000_ABCD);
        tick();
        check("hold_rvalid", 32'(bus.mem_rvalid), 32'd0);
        check("hold_rdata",  bus.mem_rdata,       32'h0000_ABCD);

        // Back-to-back: new request in the rvalid cycle
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'b0000, d, lat);
        check("b2b_first_rvalid", 32'(bus.mem_rvalid), 32'd1);
        xfer(1'b0, 32'h8000_0013, 32'h0, 4'b0000, d, lat);
        check("b2b_latency", 32'(lat), 32'(LAT));
        check("b2b_data", d, 32'h0000_00AB);

        // mem_req while busy is dropped
        xfer(1'b1, 32'h8000_0040, 32'h0000_0000, 4'b1111, d, lat);
        tick();
        bus.mem_req   = 1'b1;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = 32'h8000_0010;
        tick();
        check("busy_in_wait", 32'(busy), 32'd1);
        bus.mem_req   = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = 32'h8000_0040;
        bus.mem_wdata = 32'hFFFF_FFFF;
        bus.mem_wmask = 4'b1111;
        tick();
        bus.mem_req   = 1'b0;
        check("ign_rvalid", 32'(bus.mem_rvalid), 32'd1);
        check("ign_rdata",  bus.mem_rdata,       32'hABCD_1234);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.mem_rvalid) pulses++;
        end
        check("ign_no_extra", 32'(pulses), 32'd0);
        check("ign_busy_idle", 32'(busy), 32'd0);
        xfer(1'b0, 32'h8000_0040, 32'h0, 4'b0000, d, lat);
        check("ign_no_store", d, 32'h0000_0000);

        // Reset in WAIT discards a pending store
        xfer(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'b1111, d, lat);
        tick();
        bus.mem_req   = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = 32'h8000_0020;
        bus.mem_wdata = 32'h1234_5678;
        bus.mem_wmask = 4'b1111;
        tick();
        bus.mem_req   = 1'b0;
        check("rstw_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.mem_rvalid) pulses++;
            tick();
        end
        check("rstw_no_rvalid", 32'(pulses), 32'd0);
        xfer(1'b0, 32'h8000_0020, 32'h0, 4'b0000, d, lat);
        check("rstw_word_kept", d, 32'h0BAD_F00D);

        // Out-of-range access
        xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, d, lat);
        check("oor_latency", 32'(lat), 32'(LAT));
`ifdef DMEM_RANGE_CHECK_EN
        check("oor_data", d, 32'h0000_0000);
        check("oor_err", 32'(err), 32'd1);
        tick();
        tick();
        check("oor_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        tick();
        check("oor_err_reset", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
`else
        check("oor_err_off", 32'(err), 32'd0);
        tick();
        check("oor_err_off_later", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
